// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN max-pool compare block: default sizes,
// FSM state encoding and the most-negative-value helper.
package cnn_pkg;

   localparam int unsigned DATA_W_DEF = 12;
   localparam int unsigned N_ELEM_DEF = 9;
   localparam int unsigned IDX_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Most negative two's-complement value representable in w bits (w <= 31).
   function automatic int most_neg(input int unsigned w);
      return -(2 ** (int'(w) - 1));
   endfunction

   localparam int MOST_NEG = most_neg(DATA_W_DEF);

endpackage

// File: rtl/cnn_max_unit.sv
// Running signed maximum and first-occurrence index for one feature map.
// Optional macro CNN_POOL_RELU_EN clamps elements at zero and starts the
// running maximum at zero instead of the most negative value.
module cnn_max_unit
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     init,
   input  logic                     step,
   input  logic signed [DATA_W-1:0] elem,
   input  logic [IDX_W-1:0]         elem_idx,
   output logic signed [DATA_W-1:0] run_max,
   output logic [IDX_W-1:0]         run_idx,
   output logic signed [DATA_W-1:0] run_max_nxt_c
);

`ifdef CNN_POOL_RELU_EN
   localparam logic signed [DATA_W-1:0] INIT_VAL = '0;
`else
   localparam logic signed [DATA_W-1:0] INIT_VAL = DATA_W'(most_neg(DATA_W));
`endif

   logic signed [DATA_W-1:0] val;
   logic                     take;

   // Element conditioning and strict-greater update decision.
   always_comb begin
      val  = elem;
`ifdef CNN_POOL_RELU_EN
      if (elem[DATA_W-1]) val = '0;
`endif
      take = step && (val > run_max);
      run_max_nxt_c = run_max;
      if (init)      run_max_nxt_c = INIT_VAL;
      else if (take) run_max_nxt_c = val;
   end

   // Running max/index registers; ties keep the earlier index.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_max <= '0;
         run_idx <= '0;
      end else begin
         run_max <= run_max_nxt_c;
         if (init)      run_idx <= '0;
         else if (take) run_idx <= elem_idx;
      end
   end

endmodule

// File: rtl/cnn_pool_compare.sv
// Sequential max-pool compare of two signed feature maps: accepts a map pair,
// scans one element per cycle, reports both maxima, their indices and which
// map wins. Optional macro CNN_POOL_RELU_EN enables zero-clamping of elements.
module cnn_pool_compare
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned N_ELEM = N_ELEM_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_ELEM*DATA_W-1:0] or1_flat,
   input  logic [N_ELEM*DATA_W-1:0] or2_flat,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] max1,
   output logic signed [DATA_W-1:0] max2,
   output logic [IDX_W-1:0]         idx1,
   output logic [IDX_W-1:0]         idx2,
   output logic                     class_sel
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEM - 1);

   state_t                   state;
   state_t                   state_nxt;
   logic [IDX_W-1:0]         scan;
   logic signed [DATA_W-1:0] map1 [N_ELEM];
   logic signed [DATA_W-1:0] map2 [N_ELEM];
   logic                     accept;
   logic                     scanning;
   logic                     last;
   logic signed [DATA_W-1:0] max1_nxt;
   logic signed [DATA_W-1:0] max2_nxt;

   assign accept   = in_valid && in_ready;
   assign scanning = (state == SCAN);
   assign last     = scanning && (scan == LAST);

   // State register with handshake flags decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = SCAN;
         SCAN:    if (scan == LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Snapshot of both maps so upstream may change them during the scan.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < int'(N_ELEM); i++) begin
            map1[i] <= or1_flat[i*DATA_W +: DATA_W];
            map2[i] <= or2_flat[i*DATA_W +: DATA_W];
         end
      end
   end

   // Scan counter saturates at the last element and restarts on acceptance.
   always_ff @(posedge clk) begin
      if (rst)                       scan <= '0;
      else if (accept)               scan <= '0;
      else if (scanning && !last)    scan <= scan + IDX_W'(1);
   end

   // Winner flag captured from the final maxima on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst)         class_sel <= 1'b0;
      else if (accept) class_sel <= 1'b0;
      else if (last)   class_sel <= (max2_nxt > max1_nxt);
   end

   cnn_max_unit #(.DATA_W(DATA_W)) u_max1 (
      .clk           (clk),
      .rst           (rst),
      .init          (accept),
      .step          (scanning),
      .elem          (map1[scan]),
      .elem_idx      (scan),
      .run_max       (max1),
      .run_idx       (idx1),
      .run_max_nxt_c (max1_nxt)
   );

   cnn_max_unit #(.DATA_W(DATA_W)) u_max2 (
      .clk           (clk),
      .rst           (rst),
      .init          (accept),
      .step          (scanning),
      .elem          (map2[scan]),
      .elem_idx      (scan),
      .run_max       (max2),
      .run_idx       (idx2),
      .run_max_nxt_c (max2_nxt)
   );

endmodule

// File: tb/tb_cnn_pool_compare.sv
// Scoreboard bench for cnn_pool_compare: stimulus pushes reference results
// on acceptance, a monitor pops and compares when out_valid rises.
module tb_cnn_pool_compare;

   localparam int DW = 12;
   localparam int NE = 9;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [NE*DW-1:0]     or1_flat;
   logic [NE*DW-1:0]     or2_flat;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] max1;
   logic signed [DW-1:0] max2;
   logic [3:0]           idx1;
   logic [3:0]           idx2;
   logic                 class_sel;

   typedef struct {
      int m1;
      int i1;
      int m2;
      int i2;
      int cls;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   acc_log[$];
   exp_t pending;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic ov_prev = 1'b0;

   cnn_pool_compare dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .or1_flat  (or1_flat),
      .or2_flat  (or2_flat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .max1      (max1),
      .max2      (max2),
      .idx1      (idx1),
      .idx2      (idx2),
      .class_sel (class_sel)
   );

   always #5 clk = ~clk;

   function automatic int cond(input int x);
`ifdef CNN_POOL_RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   // Reference: value and first index of the maximum of each conditioned map.
   function automatic exp_t model(input int a[NE], input int b[NE]);
      exp_t e;
      e.m1 = cond(a[0]); e.i1 = 0;
      e.m2 = cond(b[0]); e.i2 = 0;
      for (int i = 1; i < NE; i++) begin
         if (cond(a[i]) > e.m1) begin e.m1 = cond(a[i]); e.i1 = i; end
         if (cond(b[i]) > e.m2) begin e.m2 = cond(b[i]); e.i2 = i; end
      end
      e.cls = (e.m2 > e.m1) ? 1 : 0;
      return e;
   endfunction

   function automatic logic [NE*DW-1:0] pack(input int a[NE]);
      logic [NE*DW-1:0] p;
      p = '0;
      for (int i = 0; i < NE; i++) p[i*DW +: DW] = DW'(a[i]);
      return p;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Acceptance tracker: pushes the pending reference result on each handshake.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && in_valid && in_ready) begin
         exp_q.push_back(pending);
         acc_q.push_back(cyc);
         acc_log.push_back(cyc);
      end
   end

   // Monitor: compares each new result against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      int   a;
      if (out_valid && !ov_prev) begin
         if (exp_q.size() == 0 || acc_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: out_valid with empty scoreboard (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("max1", int'(max1), e.m1);
            check("idx1", int'(idx1), e.i1);
            check("max2", int'(max2), e.m2);
            check("idx2", int'(idx2), e.i2);
            check("class_sel", int'(class_sel), e.cls);
            check("latency", cyc - a - 1, 9);
         end
      end
      ov_prev <= out_valid;
   end

   task automatic send(input int a[NE], input int b[NE]);
      int n;
      n = 0;
      @(negedge clk);
      pending  = model(a, b);
      or1_flat = pack(a);
      or2_flat = pack(b);
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      or1_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
      or2_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
      end
      @(negedge clk);
   endtask

   task automatic rand_map(output int a[NE], input int lo, input int hi);
      for (int i = 0; i < NE; i++)
         a[i] = lo + int'($urandom_range(32'(hi - lo)));
   endtask

   initial begin
      int   a[NE];
      int   b[NE];
      exp_t e;
      int   sz0;
      int   n;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      or1_flat  = '0;
      or2_flat  = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_max1", int'(max1), 0);
      check("rst_idx2", int'(idx2), 0);
      check("rst_class_sel", int'(class_sel), 0);
      rst = 1'b0;

      // Mixed map1 with a tie at the maximum, map2 all -1.
      a = '{5, -3, 7, 7, 0, 1, 2, -8, 4};
      b = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
      send(a, b);
      drain();

      // Map1 at the most negative value, map2 ascending.
      a = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
      b = '{-5, -4, -3, -2, -1, 0, 1, 2, 3};
      send(a, b);
      drain();

      // Both maps entirely negative.
      rand_map(a, -2048, -1);
      rand_map(b, -2048, -1);
      send(a, b);
      drain();

      // Random full range and tie-heavy narrow range.
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) begin
            rand_map(a, -2048, 2047);
            rand_map(b, -2048, 2047);
         end else begin
            rand_map(a, -2, 2);
            rand_map(b, -2, 2);
         end
         send(a, b);
         drain();
      end

      // Back-to-back pairs with out_ready tied high.
      rand_map(a, -2048, 2047);
      rand_map(b, -2048, 2047);
      send(a, b);
      rand_map(a, -100, 100);
      rand_map(b, -100, 100);
      send(a, b);
      check("b2b_interval", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 11);
      drain();

      // Backpressure in DONE: hold, ignore new input, then release.
      out_ready = 1'b0;
      a = '{1, 9, 3, 9, -4, 0, 2, 2, 8};
      b = '{0, 0, 10, 0, 0, 0, 0, 0, 10};
      e = model(a, b);
      send(a, b);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("hold_reached_done", int'(out_valid), 1);
      sz0 = acc_log.size();
      rand_map(a, -2048, 2047);
      rand_map(b, -2048, 2047);
      pending  = model(a, b);
      or1_flat = pack(a);
      or2_flat = pack(b);
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_max1", int'(max1), e.m1);
         check("hold_idx1", int'(idx1), e.i1);
         check("hold_max2", int'(max2), e.m2);
         check("hold_idx2", int'(idx2), e.i2);
         check("hold_class_sel", int'(class_sel), e.cls);
         check("hold_in_ready", int'(in_ready), 0);
         check("hold_out_valid", int'(out_valid), 1);
      end
      check("hold_no_accept", acc_log.size(), sz0);
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", int'(in_ready), 1);
      check("release_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("release_accepted", acc_log.size(), sz0 + 1);
      drain();

      // Reset in the middle of a scan.
      rand_map(a, -2048, 2047);
      rand_map(b, -2048, 2047);
      send(a, b);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_max1", int'(max1), 0);
      check("abort_max2", int'(max2), 0);
      check("abort_idx1", int'(idx1), 0);
      check("abort_class_sel", int'(class_sel), 0);
      exp_q.delete();
      acc_q.delete();
      rst = 1'b0;
      repeat (15) @(negedge clk);
      a = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
      b = '{2, 7, 1, 8, 2, 8, 1, 8, 2};
      send(a, b);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cnn_pool_compare.md
CNN_POOL_COMPARE -- requirements
Module: cnn_pool_compare

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, giving the signed feature-map element width.
REQ-002 The block SHALL have parameter N_ELEM, default 9, giving the elements per feature map (3x3).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: the upstream parallel CNN stage presents both feature maps.
REQ-006 Port in_ready, output, 1: the block can accept a map pair.
REQ-007 Port or1_flat, input, N_ELEM*DATA_W: feature map 1, element i at bits [i*DATA_W +: DATA_W], signed.
REQ-008 Port or2_flat, input, N_ELEM*DATA_W: feature map 2, same packing.
REQ-009 Port out_valid, output, 1: the result registers are valid.
REQ-010 Port out_ready, input, 1: the downstream stage consumes the result.
REQ-011 Port max1 / max2, output, DATA_W each: signed maximum of map 1 / map 2.
REQ-012 Port idx1 / idx2, output, 4 each: element index (0..8) of max1 / max2.
REQ-013 Port class_sel, output, 1: 1 iff max2 > max1 (strict).

Function
REQ-014 FSM states SHALL be IDLE, SCAN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE->SCAN on the edge where in_valid && in_ready: capture both maps into internal registers, set scan index to 0, and load running maxima with -2^(DATA_W-1) and indices with 0.
REQ-016 In SCAN, one element per cycle, index 0..N_ELEM-1: element i replaces the running max and index only if strictly greater, so the first occurrence wins ties.
REQ-017 After the edge processing index N_ELEM-1, state SHALL become DONE; out_valid therefore rises N_ELEM cycles after the acceptance edge, which is 9 cycles by default.
REQ-018 class_sel SHALL be registered on entry to DONE; ties SHALL give 0.
REQ-019 DONE->IDLE on the edge where out_valid && out_ready; outputs SHALL hold stable while out_ready=0.
REQ-020 Inputs SHALL be ignored outside IDLE; or*_flat changes during SCAN do not affect the result.
REQ-021 Minimum period between acceptances SHALL be N_ELEM+2 cycles (11 by default).
REQ-022 The scan counter SHALL never exceed N_ELEM-1, and the index SHALL return to 0 on each new acceptance.

Reset
REQ-023 While rst=1 at a clock edge: state=IDLE, in_ready=1 from the next cycle, out_valid=0, max1=max2=0, idx1=idx2=0, class_sel=0, scan index=0.
REQ-024 rst asserted mid-SCAN or in DONE SHALL abort the operation and discard any partial result; no out_valid pulse follows.

Configuration
REQ-025 Macro CNN_POOL_RELU_EN: when defined, each element SHALL be clamped to max(x,0) before comparison and the running maxima SHALL initialise to 0, so outputs are never negative.
REQ-026 When CNN_POOL_RELU_EN is not defined, the block SHALL compare raw signed values as in REQ-015 and REQ-016.

Structure
REQ-027 Shared package cnn_pkg SHALL hold the DATA_W/N_ELEM defaults, the FSM state encoding (2-bit IDLE=0, SCAN=1, DONE=2) and the most-negative-value constant.
REQ-028 One sub-module, cnn_max_unit, SHALL hold the running max and index for a single map; it SHALL be instantiated twice.

Verification
REQ-029 Map1 = {5,-3,7,7,0,1,2,-8,4} and map2 = all -1, without ReLU -> max1=7, idx1=2, max2=-1, idx2=0, class_sel=0, out_valid 9 cycles after acceptance.
REQ-030 Map1 all -2048, map2 = {-5,-4,...,3}, without ReLU -> max1=-2048, idx1=0, max2=3, idx2=8, class_sel=1.
REQ-031 With CNN_POOL_RELU_EN, map1 all negative and map2 all negative -> max1=max2=0, idx=0, class_sel=0.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE on the next edge, and the next pair is accepted.
REQ-033 Assert rst at scan index 4 -> next cycle state=IDLE, in_ready=1, out_valid=0, outputs=0; a new pair then completes normally.
REQ-034 Two back-to-back pairs with out_ready tied to 1 -> acceptances exactly 11 cycles apart, both results correct.
